// File: rtl/pe_cfg_pkg.sv
// Shared context-word layout, operand select encodings and opcode constants
// for the CGRA PE operand stage.
package pe_cfg_pkg;

    localparam int unsigned PE_DATA_WIDTH = 32;

    // Selects 0..N_IN-1 pick network inputs; the entries below follow N_IN=4.
    localparam logic [2:0] SEL_FB   = 3'd4;
    localparam logic [2:0] SEL_IMM  = 3'd5;
    localparam logic [2:0] SEL_ZERO = 3'd7;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_MOVC = 6'h20;

    typedef struct packed {
        logic [5:0]               opcode;
        logic [2:0]               lhs_sel;
        logic [2:0]               rhs_sel;
        logic [2:0]               pred_sel;
        logic                     pred_en;
        logic [PE_DATA_WIDTH-1:0] imm;
    } pe_cfg_t;

    localparam int unsigned CFG_W = $bits(pe_cfg_t);

endpackage

// File: rtl/pe_context_mem.sv
// Per-PE context memory: register file with synchronous write, asynchronous
// read and asynchronous clear to all-nop words.
module pe_context_mem
    import pe_cfg_pkg::*;
#(
    parameter  int unsigned CONTEXT_DEPTH = 16,
    localparam int unsigned AW            = $clog2(CONTEXT_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  pe_cfg_t       wdata,
    input  logic [AW-1:0] raddr,
    output pe_cfg_t       rdata
);

    pe_cfg_t mem [CONTEXT_DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < CONTEXT_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_operand_stage.sv
// Operand-fetch / context-sequencing stage ahead of the PE ALU.
// Optional build macro PRED_GATE_EN: false predicate on a pred_en context issues a nop.
module pe_operand_stage
    import pe_cfg_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = 32,
    parameter  int unsigned N_IN          = 4,
    parameter  int unsigned CONTEXT_DEPTH = 16,
    localparam int unsigned AW            = $clog2(CONTEXT_DEPTH),
    localparam int unsigned IIW           = AW + 1,
    localparam int unsigned OW            = DATA_WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    stall,
    input  logic [IIW-1:0]          ii,
    input  logic                    cfg_we,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [CFG_W-1:0]        cfg_data,
    input  logic [N_IN-1:0][OW-1:0] net_in,
    input  logic [DATA_WIDTH-1:0]   alu_fb,
    output logic [5:0]              alu_operation,
    output logic [OW-1:0]           alu_lhs,
    output logic [OW-1:0]           alu_rhs,
    output logic [OW-1:0]           alu_shift,
    output logic [DATA_WIDTH-1:0]   alu_predicate,
    output logic [AW-1:0]           ctx_ptr,
    output logic                    ctx_wrap
);

    // issue_ptr addresses the context read this cycle; ctx_ptr reports the
    // context behind the registered outputs, so it lags issue_ptr by one edge.
    logic [AW-1:0]  issue_ptr;
    logic           issue_wrap;
    logic [IIW-1:0] last;
    logic           at_last;
    pe_cfg_t        cur;
    logic [OW-1:0]  lhs_op, rhs_op, pred_op;
    logic           pred_true;
    logic [5:0]     op_eff;

    pe_context_mem #(.CONTEXT_DEPTH(CONTEXT_DEPTH)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (pe_cfg_t'(cfg_data)),
        .raddr (issue_ptr),
        .rdata (cur)
    );

    function automatic logic [OW-1:0] pick(input logic [2:0] sel,
                                           input logic [N_IN-1:0][OW-1:0] net,
                                           input logic [DATA_WIDTH-1:0] fb,
                                           input logic [DATA_WIDTH-1:0] imm);
        logic [OW-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            if (32'(sel) == k) v = net[k];
        end
        if (32'(sel) == N_IN)     v = {1'b1, fb};
        if (32'(sel) == N_IN + 1) v = {1'b1, imm};
        return v;
    endfunction

    always_comb begin
        last = '0;
        if (ii == '0)
            last = '0;
        else if (ii > IIW'(CONTEXT_DEPTH))
            last = IIW'(CONTEXT_DEPTH - 1);
        else
            last = ii - 1'b1;
    end

    // >= rather than == so a shrinking ii pulls an out-of-range pointer back.
    assign at_last   = {1'b0, issue_ptr} >= last;
    assign lhs_op    = pick(cur.lhs_sel,  net_in, alu_fb, cur.imm);
    assign rhs_op    = pick(cur.rhs_sel,  net_in, alu_fb, cur.imm);
    assign pred_op   = pick(cur.pred_sel, net_in, alu_fb, cur.imm);
    assign pred_true = pred_op[OW-1] & pred_op[0];

`ifdef PRED_GATE_EN
    assign op_eff = (cur.pred_en && !pred_true) ? OP_NOP : cur.opcode;
`else
    logic pred_unused;
    assign pred_unused = cur.pred_en ^ pred_true;
    assign op_eff      = cur.opcode;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_ptr     <= '0;
            issue_wrap    <= 1'b0;
            ctx_ptr       <= '0;
            ctx_wrap      <= 1'b0;
            alu_operation <= OP_NOP;
            alu_lhs       <= '0;
            alu_rhs       <= '0;
            alu_shift     <= '0;
            alu_predicate <= '0;
        end else if (!stall) begin
            if (!run) begin
                issue_ptr     <= '0;
                issue_wrap    <= 1'b0;
                ctx_ptr       <= '0;
                ctx_wrap      <= 1'b0;
                alu_operation <= OP_NOP;
                alu_lhs       <= '0;
                alu_rhs       <= '0;
                alu_shift     <= '0;
                alu_predicate <= '0;
            end else begin
                issue_ptr     <= at_last ? '0 : issue_ptr + 1'b1;
                issue_wrap    <= at_last;
                ctx_ptr       <= issue_ptr;
                ctx_wrap      <= issue_wrap;
                alu_operation <= op_eff;
                alu_lhs       <= lhs_op;
                alu_rhs       <= rhs_op;
                alu_shift     <= {1'b1, cur.imm};
                alu_predicate <= pred_op[DATA_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_pe_operand_stage.sv
// Self-checking bench for pe_operand_stage: vector table through a scoreboard
// plus hand sequences for wrap, stall, ii clamp and asynchronous reset.
module tb_pe_operand_stage;
    import pe_cfg_pkg::*;

`ifdef PRED_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic              stall = 1'b0;
    logic [4:0]        ii = 5'd1;
    logic              cfg_we = 1'b0;
    logic [3:0]        cfg_addr = '0;
    pe_cfg_t           cfg_data = '0;
    logic [3:0][32:0]  net_in = '0;
    logic [31:0]       alu_fb = '0;
    logic [5:0]        alu_operation;
    logic [32:0]       alu_lhs, alu_rhs, alu_shift;
    logic [31:0]       alu_predicate;
    logic [3:0]        ctx_ptr;
    logic              ctx_wrap;

    int unsigned total = 0;
    int unsigned bad   = 0;

    pe_operand_stage #(.DATA_WIDTH(32), .N_IN(4), .CONTEXT_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .run(run), .stall(stall), .ii(ii),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .net_in(net_in), .alu_fb(alu_fb),
        .alu_operation(alu_operation), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_shift(alu_shift), .alu_predicate(alu_predicate),
        .ctx_ptr(ctx_ptr), .ctx_wrap(ctx_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        pe_cfg_t     cfg;
        logic [5:0]  op;
        logic [32:0] lhs, rhs, shift;
        logic [31:0] pred;
    } vec_t;

    typedef struct {
        logic [5:0]  op;
        logic [32:0] lhs, rhs, shift;
        logic [31:0] pred;
    } exp_t;

    vec_t vecs[5];
    exp_t sb[$];

    function automatic pe_cfg_t mk(logic [5:0] op, logic [2:0] l, logic [2:0] r,
                                   logic [2:0] p, logic pe, logic [31:0] imm);
        pe_cfg_t c;
        c.opcode = op; c.lhs_sel = l; c.rhs_sel = r;
        c.pred_sel = p; c.pred_en = pe; c.imm = imm;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic write_ctx(input logic [3:0] a, input pe_cfg_t c);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty got op %h want entry", tag, alu_operation);
        end else begin
            e = sb.pop_front();
            chk({tag, ".op"},    alu_operation, e.op);
            chk({tag, ".lhs"},   alu_lhs,       e.lhs);
            chk({tag, ".rhs"},   alu_rhs,       e.rhs);
            chk({tag, ".shift"}, alu_shift,     e.shift);
            chk({tag, ".pred"},  alu_predicate, e.pred);
            chk({tag, ".ptr"},   ctx_ptr,       4'd0);
        end
    endtask

    task automatic issue_one(input string tag, input pe_cfg_t c, input logic [5:0] op,
                             input logic [32:0] lhs, input logic [32:0] rhs,
                             input logic [32:0] shift, input logic [31:0] pred);
        exp_t e;
        write_ctx(4'd0, c);
        e.op = op; e.lhs = lhs; e.rhs = rhs; e.shift = shift; e.pred = pred;
        sb.push_back(e);
        tick();
        pop_check(tag);
    endtask

    initial begin
        logic [3:0] exp_ptr[5];
        logic       exp_wrap[5];

        vecs[0] = '{mk(OP_ADD, 3'd1, 3'd0, SEL_ZERO, 1'b0, 32'h0), 6'h01,
                    33'h1_00000003, 33'h1_00000005, 33'h1_00000000, 32'h0};
        vecs[1] = '{mk(6'h3F, SEL_FB, SEL_IMM, 3'd3, 1'b0, 32'h10), 6'h3F,
                    33'h1_000000AA, 33'h1_00000010, 33'h1_00000010, 32'h12345678};
        vecs[2] = '{mk(OP_SUB, 3'd3, 3'd6, 3'd2, 1'b0, 32'hDEADBEEF), 6'h02,
                    33'h0_12345678, 33'h0, 33'h1_DEADBEEF, 32'h00000001};
        vecs[3] = '{mk(OP_XOR, SEL_ZERO, 3'd2, SEL_FB, 1'b1, 32'h0), GATE ? 6'h00 : 6'h05,
                    33'h0, 33'h1_00000001, 33'h1_00000000, 32'h000000AA};
        vecs[4] = '{mk(6'h06, 3'd0, 3'd1, 3'd2, 1'b1, 32'h7), 6'h06,
                    33'h1_00000005, 33'h1_00000003, 33'h1_00000007, 32'h00000001};

        net_in[0] = 33'h1_00000005;
        net_in[1] = 33'h1_00000003;
        net_in[2] = 33'h1_00000001;
        net_in[3] = 33'h0_12345678;
        alu_fb    = 32'h0000_00AA;

        #1;
        chk("rst.op", alu_operation, 6'h0);
        chk("rst.lhs", alu_lhs, 33'h0);
        chk("rst.shift", alu_shift, 33'h0);
        chk("rst.ptr", ctx_ptr, 4'h0);
        chk("rst.wrap", ctx_wrap, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        run = 1'b1; ii = 5'd1;
        for (int i = 0; i < 5; i++) begin
            issue_one($sformatf("vec%0d", i), vecs[i].cfg, vecs[i].op,
                      vecs[i].lhs, vecs[i].rhs, vecs[i].shift, vecs[i].pred);
        end

        net_in[2] = 33'h1_00000000;
        issue_one("gate_false", mk(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b1, 32'h0),
                  GATE ? 6'h00 : 6'h01, 33'h1_00000005, 33'h1_00000003, 33'h1_00000000, 32'h0);
        net_in[2] = 33'h1_00000001;
        issue_one("gate_true", mk(OP_ADD, 3'd0, 3'd1, 3'd2, 1'b1, 32'h0),
                  6'h01, 33'h1_00000005, 33'h1_00000003, 33'h1_00000000, 32'h1);

        // wrap with ii=3
        run = 1'b0;
        write_ctx(4'd0, mk(6'h01, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0));
        write_ctx(4'd1, mk(6'h02, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0));
        write_ctx(4'd2, mk(6'h03, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0));
        chk("idle.op", alu_operation, 6'h0);
        chk("idle.lhs", alu_lhs, 33'h0);
        exp_ptr  = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
        exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ii = 5'd3; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wrap%0d.ptr", i), ctx_ptr, exp_ptr[i]);
            chk($sformatf("wrap%0d.wrap", i), ctx_wrap, exp_wrap[i]);
            chk($sformatf("wrap%0d.op", i), alu_operation, {2'b0, exp_ptr[i]} + 6'd1);
        end

        // stall on a wrapped context while rewriting it
        run = 1'b0; tick();
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("prestall.ptr", ctx_ptr, 4'd0);
        chk("prestall.wrap", ctx_wrap, 1'b1);
        stall = 1'b1;
        write_ctx(4'd0, mk(6'h11, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk($sformatf("stall%0d.ptr", i), ctx_ptr, 4'd0);
            chk($sformatf("stall%0d.op", i), alu_operation, 6'h01);
            chk($sformatf("stall%0d.wrap", i), ctx_wrap, 1'b1);
        end
        stall = 1'b0;
        tick(); chk("post1.ptr", ctx_ptr, 4'd1); chk("post1.op", alu_operation, 6'h02);
        chk("post1.wrap", ctx_wrap, 1'b0);
        tick(); chk("post2.op", alu_operation, 6'h03);
        tick(); chk("post3.ptr", ctx_ptr, 4'd0); chk("post3.op", alu_operation, 6'h11);
        chk("post3.wrap", ctx_wrap, 1'b1);

        // stall beats run=0
        stall = 1'b1; run = 1'b0;
        tick(); chk("stallrun.op", alu_operation, 6'h11);
        stall = 1'b0;
        tick(); chk("run0.op", alu_operation, 6'h00);

        // ii=0 behaves as ii=1
        ii = 5'd0; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ii0_%0d.ptr", i), ctx_ptr, 4'd0);
        end

        // asynchronous reset mid-run
        ii = 5'd3;
        tick(); tick();
        chk("premid.op", alu_operation, 6'h02);
        #2 reset = 1'b1;
        #1;
        chk("amid.op", alu_operation, 6'h0);
        chk("amid.lhs", alu_lhs, 33'h0);
        chk("amid.shift", alu_shift, 33'h0);
        chk("amid.ptr", ctx_ptr, 4'h0);
        reset = 1'b0;
        tick();
        chk("after.op", alu_operation, 6'h0);
        chk("after.ptr", ctx_ptr, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
